// File: rtl/xor_gate.sv
// XOR gate with a sampled history: registered copy, rising-edge pulse,
// running parity and a saturating count of sampled ones.
module xor_gate #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             a,
    input  logic             b,
    output logic             f,
    output logic             f_q,
    output logic             f_rise,
    output logic             acc_parity,
    output logic [CNT_W-1:0] ones_cnt,
    output logic             cnt_sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             fq_q,   fq_d;
    logic             rise_q, rise_d;
    logic             par_q,  par_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;

    assign f = a ^ b;

    always_comb begin
        // NOTE: every next-state signal gets a hold default first so no latch is inferred.
        fq_d   = fq_q;
        rise_d = 1'b0;
        par_d  = par_q;
        cnt_d  = cnt_q;

        if (en) begin
            fq_d   = f;
            rise_d = f & ~fq_q;
            if (f) begin
                par_d = ~par_q;
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        // Clear beats the sample on the accumulators; f_q still follows en.
        if (clr) begin
            rise_d = 1'b0;
            par_d  = 1'b0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            fq_q   <= 1'b0;
            rise_q <= 1'b0;
            par_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            fq_q   <= fq_d;
            rise_q <= rise_d;
            par_q  <= par_d;
            cnt_q  <= cnt_d;
        end
    end

    assign f_q        = fq_q;
    assign f_rise     = rise_q;
    assign acc_parity = par_q;
    assign ones_cnt   = cnt_q;
    assign cnt_sat    = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_xor_gate.sv
// Bench for xor_gate: truth table, directed vector table, narrow-counter
// saturation sequence and randomized traffic against a counting model.
module tb_xor_gate;

    logic clk = 1'b0;
    logic rst, en, clr, a, b;

    logic        f, f_q, f_rise, acc_parity, cnt_sat;
    logic [15:0] ones_cnt;
    logic        f2, f_q2, f_rise2, acc_parity2, cnt_sat2;
    logic [1:0]  ones_cnt2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    xor_gate #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .a(a), .b(b),
        .f(f), .f_q(f_q), .f_rise(f_rise), .acc_parity(acc_parity),
        .ones_cnt(ones_cnt), .cnt_sat(cnt_sat)
    );

    xor_gate #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .a(a), .b(b),
        .f(f2), .f_q(f_q2), .f_rise(f_rise2), .acc_parity(acc_parity2),
        .ones_cnt(ones_cnt2), .cnt_sat(cnt_sat2)
    );

    typedef struct {
        logic rst, en, clr, a, b;
        logic       e_fq, e_rise, e_par;
        logic [15:0] e_cnt;
        string      name;
    } vec_t;

    // Reference model: ones sampled since the last clear/reset, kept unbounded.
    int ones_m;
    bit fq_m, rise_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit fv;
        fv = a ^ b;
        if (rst) begin
            fq_m = 0; rise_m = 0; ones_m = 0;
        end else begin
            rise_m = (!clr && en) ? (fv && !fq_m) : 1'b0;
            if (en) fq_m = fv;
            if (clr) ones_m = 0;
            else if (en && fv) ones_m++;
        end
    endtask

    task automatic check_model(input string tag);
        int sat2;
        sat2 = (ones_m > 3) ? 3 : ones_m;
        check({tag, " f"},       32'(f),          32'(a ^ b));
        check({tag, " f_q"},     32'(f_q),        32'(fq_m));
        check({tag, " f_rise"},  32'(f_rise),     32'(rise_m));
        check({tag, " parity"},  32'(acc_parity), 32'(ones_m % 2));
        check({tag, " cnt"},     32'(ones_cnt),   32'((ones_m > 65535) ? 65535 : ones_m));
        check({tag, " sat"},     32'(cnt_sat),    32'(ones_m >= 65535));
        check({tag, " cnt2"},    32'(ones_cnt2),  32'(sat2));
        check({tag, " sat2"},    32'(cnt_sat2),   32'(sat2 == 3));
        check({tag, " parity2"}, 32'(acc_parity2), 32'(ones_m % 2));
        check({tag, " rise2"},   32'(f_rise2),    32'(rise_m));
    endtask

    // Inputs are driven at the falling edge, outputs compared at the next one.
    task automatic cycle(input logic r, input logic e, input logic c, input logic aa, input logic bb);
        rst = r; en = e; clr = c; a = aa; b = bb;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        logic [1:0] ab_tt;
        logic [1:0] exp_cnt2[5];
        logic       exp_sat2[5];

        //          rst en clr a b  fq rise par cnt
        vecs.push_back('{1,0,0,0,0, 0,0,0,0, "reset1"});
        vecs.push_back('{1,1,1,1,0, 0,0,0,0, "reset2_override"});
        vecs.push_back('{0,1,0,0,0, 0,0,0,0, "pat_s1_f0"});
        vecs.push_back('{0,1,0,1,0, 1,1,1,1, "pat_s2_f1"});
        vecs.push_back('{0,1,0,0,1, 1,0,0,2, "pat_s3_f1"});
        vecs.push_back('{0,1,0,1,1, 0,0,0,2, "pat_s4_f0"});
        vecs.push_back('{0,1,0,1,0, 1,1,1,3, "pat_s5_f1"});
        vecs.push_back('{0,0,0,0,1, 1,0,1,3, "hold1"});
        vecs.push_back('{0,0,0,1,0, 1,0,1,3, "hold2"});
        vecs.push_back('{0,0,0,0,1, 1,0,1,3, "hold3"});
        vecs.push_back('{0,0,0,1,0, 1,0,1,3, "hold4"});
        vecs.push_back('{0,0,1,0,0, 1,0,0,0, "clr_no_en"});
        vecs.push_back('{0,1,0,1,0, 1,0,1,1, "cnt_to1"});
        vecs.push_back('{0,1,0,0,1, 1,0,0,2, "cnt_to2"});
        vecs.push_back('{0,1,1,1,0, 1,0,0,0, "clr_wins"});
        vecs.push_back('{0,1,0,0,0, 0,0,0,0, "f0_sample"});
        vecs.push_back('{0,1,1,0,1, 1,0,0,0, "clr_kills_rise"});
        vecs.push_back('{0,1,0,0,1, 1,0,1,1, "no_double_rise"});
        vecs.push_back('{1,1,0,1,0, 0,0,0,0, "mid_reset"});

        // Truth table with no reliance on the clock.
        rst = 1; en = 0; clr = 0;
        for (int i = 0; i < 4; i++) begin
            ab_tt = 2'(i);
            a = ab_tt[1]; b = ab_tt[0];
            #1;
            check($sformatf("truth_%0d", i), 32'(f), 32'(ab_tt[1] ^ ab_tt[0]));
            #9;
        end
        @(negedge clk);

        foreach (vecs[i]) begin
            cycle(vecs[i].rst, vecs[i].en, vecs[i].clr, vecs[i].a, vecs[i].b);
            check({vecs[i].name, " f"},      32'(f),          32'(vecs[i].a ^ vecs[i].b));
            check({vecs[i].name, " f_q"},    32'(f_q),        32'(vecs[i].e_fq));
            check({vecs[i].name, " f_rise"}, 32'(f_rise),     32'(vecs[i].e_rise));
            check({vecs[i].name, " parity"}, 32'(acc_parity), 32'(vecs[i].e_par));
            check({vecs[i].name, " cnt"},    32'(ones_cnt),   32'(vecs[i].e_cnt));
            check({vecs[i].name, " sat"},    32'(cnt_sat),    32'(0));
        end

        // Narrow counter saturates at 3 and stays there.
        exp_cnt2 = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        exp_sat2 = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        cycle(1, 0, 0, 0, 0);
        check("w2_reset cnt2", 32'(ones_cnt2), 32'(0));
        check("w2_reset sat2", 32'(cnt_sat2),  32'(0));
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 0, 1, 0);
            check($sformatf("w2_s%0d cnt2", i + 1), 32'(ones_cnt2), 32'(exp_cnt2[i]));
            check($sformatf("w2_s%0d sat2", i + 1), 32'(cnt_sat2),  32'(exp_sat2[i]));
        end
        check("w2 parity2", 32'(acc_parity2), 32'(1));
        cycle(0, 0, 1, 1, 1);
        check("w2_clr cnt2", 32'(ones_cnt2), 32'(0));
        check("w2_clr sat2", 32'(cnt_sat2),  32'(0));

        // Randomized traffic against the model.
        cycle(1, 0, 0, 0, 0);
        check_model("rnd_init");
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom));
            check_model("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xor_gate.md
XOR_GATE -- requirements
Module: xor_gate

Interface
REQ-001 Parameter: CNT_W, default 16, width of the ones counter; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: en  input  1  sample enable for all registered state.
REQ-005 Port: clr  input  1  synchronous clear of accumulators only.
REQ-006 Port: a  input  1  XOR operand A.
REQ-007 Port: b  input  1  XOR operand B.
REQ-008 Port: f  output  1  combinational a XOR b.
REQ-009 Port: f_q  output  1  registered copy of f.
REQ-010 Port: f_rise  output  1  one-cycle pulse on sampled 0->1 transition of f.
REQ-011 Port: acc_parity  output  1  running XOR of all sampled f values.
REQ-012 Port: ones_cnt  output  CNT_W  saturating count of sampled cycles with f=1.
REQ-013 Port: cnt_sat  output  1  high while ones_cnt equals 2^CNT_W-1.

Function
REQ-014 f SHALL equal a XOR b combinationally with zero latency, independent of clk, rst, en and clr.
REQ-015 A "sample" SHALL occur on a rising clk edge with rst=0 and en=1.
REQ-016 On a sample, f_q SHALL load f; with en=0, f_q SHALL hold.
REQ-017 On a sample, f_rise SHALL be set to (f AND NOT f_q-before-edge); on any edge without a sample, f_rise SHALL be 0, so it is never high for two consecutive cycles.
REQ-018 On a sample with f=1, acc_parity SHALL toggle; otherwise it SHALL hold.
REQ-019 On a sample with f=1, ones_cnt SHALL increment by 1 unless already 2^CNT_W-1, where it SHALL hold (no wrap).
REQ-020 cnt_sat SHALL be combinationally decoded from ones_cnt (all ones).
REQ-021 clr=1 at an edge (rst=0) SHALL set acc_parity=0, ones_cnt=0, f_rise=0, regardless of en and f; f_q SHALL still follow REQ-016.
REQ-022 Priority SHALL be rst > clr > en; clr with en=1 and f=1 in the same cycle SHALL yield ones_cnt=0 and acc_parity=0 (clear wins, that sample is not counted).
REQ-023 Inputs a, b, en and clr SHALL be treated as synchronous to clk; no internal synchronizers.

Reset
REQ-024 rst=1 at a rising edge SHALL set f_q=0, f_rise=0, acc_parity=0, ones_cnt=0; cnt_sat is then 0.
REQ-025 Reset asserted mid-operation SHALL take effect at the next edge, overriding en and clr.
REQ-026 During reset, f SHALL continue to track a XOR b.

Verification
REQ-027 Truth table, no clock required: (a,b)=(0,0),(0,1),(1,0),(1,1) each held 10 ns -> f=0,1,1,0 after each change.
REQ-028 rst=1 for 2 cycles, then release -> f_q=0, f_rise=0, acc_parity=0, ones_cnt=0, cnt_sat=0.
REQ-029 en=1, f pattern 0,1,1,0,1 over 5 samples -> ones_cnt=3, acc_parity=1, f_rise high exactly the cycles after samples 2 and 5.
REQ-030 en=0 with a^b=1 for 4 cycles -> ones_cnt, acc_parity and f_q unchanged, f_rise=0.
REQ-031 CNT_W=2, en=1, f=1 for 5 samples -> ones_cnt goes 1,2,3,3,3; cnt_sat=1 from the third sample on.
REQ-032 ones_cnt=2, then one edge with clr=1, en=1, f=1 -> ones_cnt=0, acc_parity=0, f_q=1.
